// File: rtl/seis_b_pkg.sv
// Shared types and constants for the seis_b 4-input population counter.
package seis_b_pkg;

  localparam int unsigned COUNT_W = 3;

  typedef logic [COUNT_W-1:0] count_t;

  // Largest count four inputs can produce; the 3-bit code never saturates.
  localparam count_t COUNT_MAX = 3'd4;

  // Odd parity of the four data bits, which always equals the count LSB.
  function automatic logic parity4(input logic [3:0] vec);
    return ^vec;
  endfunction

endpackage

// File: rtl/seis_b_popcount.sv
// Combinational 4-bit population count: two pair sums feeding one final adder.
module seis_b_popcount
  import seis_b_pkg::*;
(
  input  logic [3:0] vec_i,
  output count_t     count_o
);

  logic [1:0] sum_lo;
  logic [1:0] sum_hi;

  always_comb begin
    sum_lo  = {1'b0, vec_i[0]} + {1'b0, vec_i[1]};
    sum_hi  = {1'b0, vec_i[2]} + {1'b0, vec_i[3]};
    count_o = {1'b0, sum_lo} + {1'b0, sum_hi};
  end

endmodule

// File: rtl/seis_b.sv
// Registered 4-input population counter with valid-qualified pipeline.
// Optional odd-parity output p is enabled by defining SEISB_PARITY_EN.
module seis_b
  import seis_b_pkg::*;
#(
  parameter int unsigned IN_REG = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output logic out_valid,
  output logic x,
  output logic y,
  output logic z
`ifdef SEISB_PARITY_EN
  ,
  output logic p
`endif
);

  logic [3:0] in_vec;
  logic [3:0] dec_vec;
  logic       dec_valid;
  count_t     dec_count;

  assign in_vec = {a, b, c, d};

  if (IN_REG != 0) begin : g_in_reg
    logic [3:0] vec_q;
    logic       valid_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        vec_q   <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= in_valid;
        if (in_valid) begin
          vec_q <= in_vec;
        end
      end
    end

    assign dec_vec   = vec_q;
    assign dec_valid = valid_q;
  end else begin : g_in_bypass
    assign dec_vec   = in_vec;
    assign dec_valid = in_valid;
  end

  seis_b_popcount u_popcount (
    .vec_i   (dec_vec),
    .count_o (dec_count)
  );

  count_t count_d, count_q;
  logic   valid_q;

  // Result only advances with a valid vector; otherwise the last count is held.
  always_comb begin
    count_d = count_q;
    if (dec_valid) begin
      count_d = dec_count;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      count_q <= count_d;
      valid_q <= dec_valid;
    end
  end

  assign {x, y, z} = count_q;
  assign out_valid = valid_q;

`ifdef SEISB_PARITY_EN
  logic parity_d, parity_q;

  always_comb begin
    parity_d = parity_q;
    if (dec_valid) begin
      parity_d = parity4(dec_vec);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign p = parity_q;
`endif

endmodule

// File: tb/tb_seis_b.sv
// Scoreboard bench for seis_b: one instance per IN_REG setting sharing stimulus.
module tb_seis_b;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b1;
  logic a = 1'b1, b = 1'b1, c = 1'b1, d = 1'b1;

  logic ov_r, x_r, y_r, z_r;
  logic ov_d, x_d, y_d, z_d;
`ifdef SEISB_PARITY_EN
  logic p_r, p_d;
`endif

  always #5 clk = ~clk;

  seis_b #(.IN_REG(1)) dut_reg (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .out_valid (ov_r),
    .x         (x_r),
    .y         (y_r),
    .z         (z_r)
`ifdef SEISB_PARITY_EN
    ,
    .p         (p_r)
`endif
  );

  seis_b #(.IN_REG(0)) dut_dir (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .out_valid (ov_d),
    .x         (x_d),
    .y         (y_d),
    .z         (z_d)
`ifdef SEISB_PARITY_EN
    ,
    .p         (p_d)
`endif
  );

  typedef struct {
    int         samp;
    int         due;
    logic [2:0] cnt;
  } exp_t;

  exp_t       qr[$];
  exp_t       qd[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  logic       rsamp = 1'b0;
  bit         armed = 1'b0;
  logic [2:0] held_r = 3'd0;
  logic [2:0] held_d = 3'd0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic lane_step(input string ln, input logic ov, input logic [2:0] xyz,
                           input bit have, input exp_t head, inout logic [2:0] held,
                           output bit pop);
    pop = 1'b0;
    if (rsamp) begin
      chk({ln, "_rst_valid"}, ov, 0);
      chk({ln, "_rst_xyz"}, xyz, 0);
      held = 3'd0;
    end else if (have) begin
      chk({ln, "_valid"}, ov, 1);
      chk({ln, "_xyz"}, xyz, head.cnt);
      held = head.cnt;
      pop  = 1'b1;
    end else begin
      chk({ln, "_idle_valid"}, ov, 0);
      chk({ln, "_hold_xyz"}, xyz, held);
    end
  endtask

  // Monitor: sample on the falling edge after each rising edge.
  always begin
    bit   have;
    bit   pop;
    exp_t head;
    @(posedge clk);
    cyc++;
    rsamp = rst;
    if (rsamp) armed = 1'b1;
    @(negedge clk);
    if (armed) begin
      if (rsamp) begin
        while (qr.size() > 0 && qr[0].samp < cyc) void'(qr.pop_front());
        while (qd.size() > 0 && qd[0].samp < cyc) void'(qd.pop_front());
      end
      have = 1'b0;
      head = '{samp: 0, due: 0, cnt: 3'd0};
      if (qr.size() > 0 && qr[0].due == cyc) begin
        have = 1'b1;
        head = qr[0];
      end
      lane_step("reg", ov_r, {x_r, y_r, z_r}, have, head, held_r, pop);
      if (pop) void'(qr.pop_front());
`ifdef SEISB_PARITY_EN
      chk("reg_p", p_r, held_r[0]);
`endif
      have = 1'b0;
      head = '{samp: 0, due: 0, cnt: 3'd0};
      if (qd.size() > 0 && qd[0].due == cyc) begin
        have = 1'b1;
        head = qd[0];
      end
      lane_step("dir", ov_d, {x_d, y_d, z_d}, have, head, held_d, pop);
      if (pop) void'(qd.pop_front());
`ifdef SEISB_PARITY_EN
      chk("dir_p", p_d, held_d[0]);
`endif
    end
  end

  // Inputs applied just after edge k are captured at edge k+1.
  task automatic drive(input logic r, input logic v, input logic [3:0] vec);
    logic [2:0] cnt;
    @(posedge clk);
    #1;
    rst      = r;
    in_valid = v;
    {a, b, c, d} = vec;
    cnt = 3'($countones(vec));
    if (!r && v) begin
      qr.push_back('{samp: cyc + 1, due: cyc + 2, cnt: cnt});
      qd.push_back('{samp: cyc + 1, due: cyc + 1, cnt: cnt});
    end
  endtask

  initial begin
    repeat (3) drive(1'b1, 1'b1, 4'b1111);
    repeat (3) drive(1'b0, 1'b0, 4'b0000);

    for (int i = 0; i < 16; i++) drive(1'b0, 1'b1, 4'(i));
    repeat (3) drive(1'b0, 1'b0, 4'b0000);

    drive(1'b0, 1'b1, 4'b0111);
    repeat (3) drive(1'b0, 1'b0, 4'b1111);

    drive(1'b0, 1'b1, 4'b1111);
    drive(1'b1, 1'b0, 4'b0000);
    repeat (3) drive(1'b0, 1'b0, 4'b0000);

    drive(1'b0, 1'b1, 4'b1011);
    repeat (2) drive(1'b0, 1'b0, 4'b0000);

    for (int i = 0; i < 40; i++) begin
      drive(($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)));
    end
    repeat (4) drive(1'b0, 1'b0, 4'b0000);

    @(posedge clk);
    #1;
    chk("reg_queue_drained", qr.size(), 0);
    chk("dir_queue_drained", qd.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
